// File: rtl/shift_pkg.sv
// Shared shift-unit definitions: operation codes and a bit-reverse helper used
// to run left shifts through the right-shifting barrel.
package shift_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  // Widest operand the reverse helper handles; narrower values sit in the top bits.
  localparam int REV_W = 64;

  function automatic logic [REV_W-1:0] bit_rev(input logic [REV_W-1:0] x);
    logic [REV_W-1:0] r;
    for (int i = 0; i < REV_W; i++) r[i] = x[REV_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One barrel level: conditional right shift by AMT with zero, sign or wrap fill.
// Purely combinational, no handshake of its own.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] dat_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] dat_o
);

  logic [AMT-1:0] fill;

  always_comb begin
    fill = '0;
    if (mode_i == SHIFT_ROR) fill = dat_i[AMT-1:0];
    else if (sign_i)         fill = '1;
    dat_o = en_i ? {fill, dat_i[WIDTH-1:AMT]} : dat_i;
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROR unit, STAGES cycles latency, one op per cycle.
// Valid/ready per slice; a full pipe stalls in_ready only while out_ready is low.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int  WIDTH  = 32,
  parameter int  STAGES = 2,
  parameter int  TAGW   = 5,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAGW-1:0]  out_tag
);

  // First barrel level handled by slice s; slice s registers after level stage_lo(s+1)-1.
  function automatic int stage_lo(input int s);
    return (s * SHW) / STAGES;
  endfunction

  function automatic int stage_of(input int k);
    int r;
    r = 0;
    for (int s = 0; s < STAGES; s++) if (k >= stage_lo(s)) r = s;
    return r;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic [1:0]        mode_q  [STAGES];
  logic [1:0]        mode_d  [STAGES];
  logic [SHW-1:0]    shamt_q [STAGES];
  logic [SHW-1:0]    shamt_d [STAGES];
  logic              sign_q  [STAGES];
  logic              sign_d  [STAGES];
  logic [WIDTH-1:0]  dat_q   [STAGES];
  logic [WIDTH-1:0]  dat_d   [STAGES];
  logic [TAGW-1:0]   tag_q   [STAGES];
  logic [TAGW-1:0]   tag_d   [STAGES];
  logic [STAGES:0]   rdy;

  for (genvar s = 0; s < STAGES; s++) begin : sl
    localparam int HI = stage_lo(s + 1);
    logic [1:0]       mode;
    logic [SHW-1:0]   shamt;
    logic             sign;
    logic [WIDTH-1:0] dat;
    logic [TAGW-1:0]  tag;
    logic             vld;

    if (s == 0) begin : g_src_in
      logic [REV_W-1:0] a_rev;
      assign a_rev = bit_rev(REV_W'(in_a));
      assign mode  = in_mode;
      assign shamt = in_shamt;
      assign sign  = (in_mode == SHIFT_SRA) & in_a[WIDTH-1];
      assign dat   = (in_mode == SHIFT_SLL) ? a_rev[REV_W-1 -: WIDTH] : in_a;
      assign tag   = in_tag;
      assign vld   = in_valid;
      if (WIDTH < REV_W) begin : g_pad
        logic pad_unused;
        assign pad_unused = ^a_rev[REV_W-WIDTH-1:0];
      end
    end else begin : g_src_q
      assign mode  = mode_q[s-1];
      assign shamt = shamt_q[s-1];
      assign sign  = sign_q[s-1];
      assign dat   = dat_q[s-1];
      assign tag   = tag_q[s-1];
      assign vld   = vld_q[s-1];
    end

    // Undo the SLL reversal before the last register so out_y comes straight from a flop.
    if (s == STAGES - 1) begin : g_last
      logic [REV_W-1:0] y_rev;
      assign y_rev    = bit_rev(REV_W'(lv[HI-1].y));
      assign dat_d[s] = (mode == SHIFT_SLL) ? y_rev[REV_W-1 -: WIDTH] : lv[HI-1].y;
      if (WIDTH < REV_W) begin : g_pad
        logic pad_unused;
        assign pad_unused = ^y_rev[REV_W-WIDTH-1:0];
      end
    end else begin : g_mid
      assign dat_d[s] = lv[HI-1].y;
    end

    assign mode_d[s]  = mode;
    assign shamt_d[s] = shamt;
    assign sign_d[s]  = sign;
    assign tag_d[s]   = tag;
    assign vld_d[s]   = vld;
  end

  for (genvar k = 0; k < SHW; k++) begin : lv
    localparam int S = stage_of(k);
    logic [WIDTH-1:0] x, y;
    if (k == stage_lo(S)) begin : g_head
      assign x = sl[S].dat;
    end else begin : g_chain
      assign x = lv[k-1].y;
    end
    shift_level #(.WIDTH(WIDTH), .AMT(1 << k)) u_level (
      .dat_i  (x),
      .en_i   (sl[S].shamt[k]),
      .mode_i (sl[S].mode),
      .sign_i (sl[S].sign),
      .dat_o  (y)
    );
  end

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) rdy[s] = !vld_q[s] | rdy[s+1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        mode_q[s]  <= '0;
        shamt_q[s] <= '0;
        sign_q[s]  <= 1'b0;
        dat_q[s]   <= '0;
        tag_q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush)       vld_q[s] <= 1'b0;
        else if (rdy[s]) vld_q[s] <= vld_d[s];
        // Flush kills only the valid bits; payload registers keep their contents.
        if (!flush && rdy[s] && vld_d[s]) begin
          mode_q[s]  <= mode_d[s];
          shamt_q[s] <= shamt_d[s];
          sign_q[s]  <= sign_d[s];
          dat_q[s]   <= dat_d[s];
          tag_q[s]   <= tag_d[s];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_y     = dat_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Randomised and directed bench for shift_pipe (WIDTH=32, STAGES=2) against a queue-based model.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_mode;
  logic [31:0] in_a, out_y;
  logic [4:0]  in_shamt, in_tag, out_tag;

  int checks = 0;
  int errors = 0;

  shift_pipe #(.WIDTH(32), .STAGES(2), .TAGW(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] a, input logic [4:0] sh);
    logic [63:0] w;
    case (m)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return 32'($signed(a) >>> sh);
      default: begin w = {a, a} >> sh; return w[31:0]; end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [31:0] a, input logic [4:0] sh,
                        input logic [4:0] tg, output logic [31:0] y, output logic [4:0] yt, output int lat);
    in_valid = 1'b1; in_mode = m; in_a = a; in_shamt = sh; in_tag = tg; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL op_in_ready got %b want 1", in_ready); end
    lat = 0;
    do begin
      @(posedge clk); #1; in_valid = 1'b0; lat++;
      @(negedge clk);
    end while (out_valid !== 1'b1 && lat < 20);
    y = out_y; yt = out_tag;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = '0; in_a = '0; in_shamt = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_y !== 32'h0 || out_tag !== 5'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%b y=%h t=%h r=%b want 0 0 0 1", out_valid, out_y, out_tag, in_ready);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release got v=%b r=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  tm [9] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] ta [9] = '{32'h1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h12345678,
                            32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    logic [4:0]  ts [9] = '{5'd31, 5'd4, 5'd4, 5'd31, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] te [9] = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'hFFFFFFFF, 32'h78123456,
                            32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    logic [31:0] y; logic [4:0] yt; int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(tm[i], ta[i], ts[i], 5'(i + 3), y, yt, lat);
      checks++;
      if (y !== te[i] || yt !== 5'(i + 3) || lat != 2) begin
        errors++;
        $display("FAIL directed_%0d got y=%h tag=%0d lat=%0d want y=%h tag=%0d lat=2",
                 i, y, yt, lat, te[i], i + 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ey[$]; logic [4:0] et[$];
    logic [31:0] hy, wy; logic [4:0] ht, wt;
    logic hold = 1'b0, pend = 1'b0;
    int acc = 0, outs = 0, drop_acc = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      if (acc < 4) begin
        if (!pend) begin
          in_mode = 2'($urandom); in_a = $urandom; in_shamt = 5'($urandom); in_tag = 5'(acc + 1);
          pend = 1'b1;
        end
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (drop_acc < 0 && in_ready === 1'b0) drop_acc = acc;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_y !== hy || out_tag !== ht) begin
          errors++; $display("FAIL b2b_stable got v=%b y=%h t=%0d want 1 %h %0d", out_valid, out_y, out_tag, hy, ht);
        end
      end
      if (out_valid && out_ready) begin
        checks++; outs++;
        if (et.size() == 0) begin
          errors++; $display("FAIL b2b_extra got tag=%0d want none", out_tag);
        end else begin
          wy = ey.pop_front(); wt = et.pop_front();
          if (out_y !== wy || out_tag !== wt) begin
            errors++; $display("FAIL b2b_order got y=%h t=%0d want y=%h t=%0d", out_y, out_tag, wy, wt);
          end
        end
      end
      if (in_valid && in_ready) begin
        ey.push_back(model(in_mode, in_a, in_shamt)); et.push_back(in_tag); acc++; pend = 1'b0;
      end
      hold = out_valid && !out_ready; hy = out_y; ht = out_tag;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (drop_acc != 2) begin errors++; $display("FAIL b2b_drop got accepts=%0d want 2", drop_acc); end
    checks++;
    if (outs != 4 || acc != 4) begin errors++; $display("FAIL b2b_count got out=%0d acc=%0d want 4 4", outs, acc); end
  endtask

  task automatic test_flush();
    logic [31:0] ya, y; logic [4:0] yt; int lat;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'b01; in_a = 32'hF0F0_1234; in_shamt = 5'd3; in_tag = 5'd10;
    ya = model(2'b01, 32'hF0F0_1234, 5'd3);
    @(negedge clk);
    in_mode = 2'b00; in_a = 32'h0000_00FF; in_shamt = 5'd9; in_tag = 5'd11;
    @(negedge clk);
    in_mode = 2'b11; in_a = 32'hDEAD_BEEF; in_shamt = 5'd5; in_tag = 5'd12; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got v=%b want 0", out_valid); end
    checks++;
    if (out_y !== ya) begin errors++; $display("FAIL flush_data got y=%h want %h", out_y, ya); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got v=%b want 0", out_valid); end
    end
    run_op(2'b10, 32'h8765_4321, 5'd12, 5'd13, y, yt, lat);
    checks++;
    if (y !== 32'hFFF8_7654 || yt !== 5'd13 || lat != 2) begin
      errors++; $display("FAIL flush_after got y=%h t=%0d lat=%0d want fff87654 13 2", y, yt, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int n = 0;
    in_valid = 1'b1; in_mode = 2'b11; in_a = 32'hCAFE_0001; in_shamt = 5'd1; in_tag = 5'd7; out_ready = 1'b0;
    do begin @(posedge clk); #1; in_valid = 1'b0; n++; @(negedge clk); end while (out_valid !== 1'b1 && n < 10);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_setup got v=%b want 1", out_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_y !== 32'h0 || out_tag !== 5'h0) begin
      errors++; $display("FAIL areset_now got v=%b y=%h t=%h want 0 0 0", out_valid, out_y, out_tag);
    end
    @(negedge clk);
    resetn = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", in_ready); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_ghost got v=%b want 0", out_valid); end
    end
  endtask

  task automatic test_random(input int n_ops);
    logic [31:0] ey[$]; logic [4:0] et[$];
    logic [31:0] hy, wy; logic [4:0] ht, wt;
    logic hold = 1'b0, pend = 1'b0, exp_rdy;
    int sent = 0, got = 0, cyc = 0;
    while (got < n_ops && cyc < 5000) begin
      @(negedge clk);
      if (pend || (sent < n_ops && $urandom_range(0, 3) != 0)) begin
        if (!pend) begin
          in_mode = 2'($urandom); in_a = $urandom; in_tag = 5'($urandom);
          case ($urandom_range(0, 3))
            0: in_shamt = 5'd0;
            1: in_shamt = 5'd31;
            default: in_shamt = 5'($urandom);
          endcase
          pend = 1'b1;
        end
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !(ey.size() == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_in_ready cyc=%0d got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_y !== hy || out_tag !== ht) begin
          errors++; $display("FAIL rand_stable got v=%b y=%h t=%0d want 1 %h %0d", out_valid, out_y, out_tag, hy, ht);
        end
      end
      if (out_valid && out_ready) begin
        checks++; got++;
        if (ey.size() == 0) begin
          errors++; $display("FAIL rand_extra got y=%h want none", out_y);
        end else begin
          wy = ey.pop_front(); wt = et.pop_front();
          if (out_y !== wy || out_tag !== wt) begin
            errors++; $display("FAIL rand_result got y=%h t=%0d want y=%h t=%0d", out_y, out_tag, wy, wt);
          end
        end
      end
      if (in_valid && in_ready) begin
        ey.push_back(model(in_mode, in_a, in_shamt)); et.push_back(in_tag); sent++; pend = 1'b0;
      end
      hold = out_valid && !out_ready; hy = out_y; ht = out_tag;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != n_ops) begin errors++; $display("FAIL rand_drain got %0d results want %0d", got, n_ops); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random(300);
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
